ysyx_axi4_sram_slave: RTL

AXI4 responder (slave) backing a word-addressed on-chip SRAM, intended as the memory-side endpoint that answers the core's AXI4 master port in simulation and FPGA builds. It accepts one outstanding transaction at a time: either a read burst or a write burst. It supports FIXED and INCR bursts on a 64-bit data bus and returns OKAY/SLVERR responses.

---
 rtl/ysyx_axi4_sram_slave.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_axi4_sram_slave.sv
// AXI4 slave backed by a 64-bit word SRAM: one outstanding read or write burst, FIXED/INCR, OKAY/SLVERR.
// Optional random ready stalls are enabled by defining YSYX_AXI_SLAVE_DELAY_EN.
module ysyx_axi4_sram_slave #(
  parameter int                ADDR_W    = 32,
  parameter int                ID_W      = 4,
  parameter int                MEM_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        arburst,
  input  logic [2:0]        arsize,
  input  logic [7:0]        arlen,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [63:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [1:0]        awburst,
  input  logic [2:0]        awsize,
  input  logic [7:0]        awlen,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [63:0]       wdata,
  input  logic [7:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RD    = 2'd1;
  localparam logic [1:0] S_WR    = 2'd2;
  localparam logic [1:0] S_WRESP = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off        = a - BASE_ADDR;
    f_in_range = (a >= BASE_ADDR) && ((off >> 3) < ADDR_W'(MEM_WORDS));
  endfunction

  function automatic logic [IDX_W-1:0] f_index(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off     = (a - BASE_ADDR) >> 3;
    f_index = off[IDX_W-1:0];
  endfunction

  function automatic logic f_burst_ok(input logic [1:0] burst);
    f_burst_ok = (burst == 2'b00) || (burst == 2'b01);
  endfunction

  // FIXED keeps the address; INCR steps by the beat size. Error bursts never touch memory.
  function automatic logic [ADDR_W-1:0] f_next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [2:0]        size,
                                                    input logic [1:0]        burst);
    f_next_addr = (burst == 2'b01) ? (a + (ADDR_W'(1) << size)) : a;
  endfunction

  logic [1:0]        r_state;
  logic              r_started;
  logic              r_last_rd;
  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic [7:0]        r_cnt;
  logic              r_err;
  logic              r_rvalid;
  logic [63:0]       r_rdata;
  logic [1:0]        r_rresp;
  logic              r_rlast;
  logic [ID_W-1:0]   r_rid;
  logic              r_bvalid;
  logic [1:0]        r_bresp;
  logic [ID_W-1:0]   r_bid;
  logic [63:0]       r_mem [MEM_WORDS];

  logic              w_gate;
  logic              w_idle;
  logic              w_grant_rd;
  logic              w_grant_wr;
  logic              w_arready;
  logic              w_awready;
  logic              w_wready;
  logic              w_ar_hs;
  logic              w_aw_hs;
  logic              w_r_hs;
  logic              w_w_hs;
  logic              w_cnt_last;
  logic [ADDR_W-1:0] w_next_addr;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [1:0]        w_rd_burst;
  logic              w_rd_ok;
  logic [63:0]       w_rd_word;
  logic              w_wr_ok;
  logic              w_wr_err;
  logic [IDX_W-1:0]  w_wr_idx;

`ifdef YSYX_AXI_SLAVE_DELAY_EN
  logic [7:0] r_lfsr;

  // Free-running x^8+x^6+x^5+x^4+1 LFSR; bit 0 gates the ready outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= 8'h01;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_gate = r_lfsr[0];
`else
  assign w_gate = 1'b1;
`endif

  // Round-robin: on contention, a write wins only if the previous grant was a read.
  assign w_idle     = (r_state == S_IDLE);
  assign w_grant_rd = arvalid && (!awvalid || !r_last_rd);
  assign w_grant_wr = awvalid && (!arvalid || r_last_rd);
  assign w_arready  = w_idle && r_started && w_gate && w_grant_rd;
  assign w_awready  = w_idle && r_started && w_gate && w_grant_wr;
  assign w_wready   = (r_state == S_WR) && w_gate;

  assign w_ar_hs    = arvalid && w_arready;
  assign w_aw_hs    = awvalid && w_awready;
  assign w_r_hs     = (r_state == S_RD) && r_rvalid && rready;
  assign w_w_hs     = wvalid && w_wready;
  assign w_cnt_last = (r_cnt == r_len);

  assign w_next_addr = f_next_addr(r_addr, r_size, r_burst);

  // In IDLE the first read beat is fetched from the incoming AR; afterwards from the advanced address.
  assign w_rd_addr  = w_idle ? araddr : w_next_addr;
  assign w_rd_burst = w_idle ? arburst : r_burst;
  assign w_rd_ok    = f_burst_ok(w_rd_burst) && f_in_range(w_rd_addr);
  assign w_rd_word  = w_rd_ok ? r_mem[f_index(w_rd_addr)] : 64'h0;

  assign w_wr_ok  = f_burst_ok(r_burst) && f_in_range(r_addr);
  assign w_wr_err = !w_wr_ok || (wlast != w_cnt_last);
  assign w_wr_idx = f_index(r_addr);

  // Transaction FSM and registered R/B channel outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_started <= 1'b0;
      r_last_rd <= 1'b0;
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= 8'd0;
      r_size    <= 3'd0;
      r_burst   <= 2'b00;
      r_cnt     <= 8'd0;
      r_err     <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 64'h0;
      r_rresp   <= 2'b00;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_bid     <= '0;
    end else begin
      r_started <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_ar_hs) begin
            r_id      <= arid;
            r_addr    <= araddr;
            r_len     <= arlen;
            r_size    <= arsize;
            r_burst   <= arburst;
            r_cnt     <= 8'd0;
            r_last_rd <= 1'b1;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rd_word;
            r_rresp   <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
            r_rlast   <= (arlen == 8'd0);
            r_rid     <= arid;
            r_state   <= S_RD;
          end else if (w_aw_hs) begin
            r_id      <= awid;
            r_addr    <= awaddr;
            r_len     <= awlen;
            r_size    <= awsize;
            r_burst   <= awburst;
            r_cnt     <= 8'd0;
            r_last_rd <= 1'b0;
            r_err     <= 1'b0;
            r_state   <= S_WR;
          end else begin
            r_state   <= S_IDLE;
          end
        end
        S_RD: begin
          if (w_r_hs) begin
            if (r_rlast) begin
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_cnt   <= r_cnt + 8'd1;
              r_addr  <= w_next_addr;
              r_rdata <= w_rd_word;
              r_rresp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
              r_rlast <= ((r_cnt + 8'd1) == r_len);
            end
          end else begin
            r_state <= S_RD;
          end
        end
        S_WR: begin
          if (w_w_hs) begin
            r_cnt  <= r_cnt + 8'd1;
            r_addr <= w_next_addr;
            r_err  <= r_err || w_wr_err;
            if (w_cnt_last) begin
              r_bvalid <= 1'b1;
              r_bid    <= r_id;
              r_bresp  <= (r_err || w_wr_err) ? RESP_SLVERR : RESP_OKAY;
              r_state  <= S_WRESP;
            end else begin
              r_state  <= S_WR;
            end
          end else begin
            r_state <= S_WR;
          end
        end
        S_WRESP: begin
          if (bready) begin
            r_bvalid <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_state  <= S_WRESP;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Byte-lane SRAM writes; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_w_hs && w_wr_ok) begin
      for (int b = 0; b < 8; b++) begin
        if (wstrb[b]) begin
          r_mem[w_wr_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign arready = w_arready;
  assign awready = w_awready;
  assign wready  = w_wready;
  assign rvalid  = r_rvalid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign rlast   = r_rlast;
  assign rid     = r_rid;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign bid     = r_bid;

endmodule
